// File: rtl/fc_pkg.sv
// Shared types and constants for the FC scheduler: FSM state encoding, default
// stream sizes, and the feature/score data types.
package fc_pkg;

    localparam int unsigned NUM_IN_DEF  = 120;
    localparam int unsigned NUM_OUT_DEF = 10;
    localparam int unsigned FEAT_W      = 16;
    localparam int unsigned SCORE_W     = 20;
    localparam int unsigned ADDR_W      = 7;
    localparam int unsigned IDX_W       = 4;

    typedef logic signed [FEAT_W-1:0]  feat_t;
    typedef logic signed [SCORE_W-1:0] score_t;

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StAlign,
        StStream,
        StWait,
        StCapture,
        StDone
    } fc_state_e;

    function automatic int unsigned max_of(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/fc_scheduler_if.sv
// Feature-RAM read port and FC datapath port of the scheduler; the master side is
// the scheduler, the slave side is the RAM plus FC datapath.
interface fc_scheduler_if;
    import fc_pkg::*;

    logic                feat_rd;
    logic [ADDR_W-1:0]   feat_addr;
    feat_t               feat_rdata;
    logic                fc_rst;
    feat_t               fc_fan_in;
    logic                fc_ready;
    score_t              fc_fan_out;

    modport master (
        output feat_rd,
        output feat_addr,
        output fc_rst,
        output fc_fan_in,
        input  feat_rdata,
        input  fc_ready,
        input  fc_fan_out
    );

    modport slave (
        input  feat_rd,
        input  feat_addr,
        input  fc_rst,
        input  fc_fan_in,
        output feat_rdata,
        output fc_ready,
        output fc_fan_out
    );

endinterface

// File: rtl/fc_argmax.sv
// Serial running maximum over a stream of signed scores; only built when
// FC_ARGMAX_EN is defined. Outputs already include the sample presented this cycle.
module fc_argmax
    import fc_pkg::*;
#(
    parameter int unsigned IdxW = 4
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            clr_i,
    input  logic            vld_i,
    input  logic [IdxW-1:0] idx_i,
    input  score_t          val_i,
    output score_t          max_o,
    output logic [IdxW-1:0] idx_o
);

    logic            have_q, have_d;
    score_t          max_q, max_d;
    logic [IdxW-1:0] idx_q, idx_d;

    always_comb begin
        have_d = have_q;
        max_d  = max_q;
        idx_d  = idx_q;
        if (clr_i) begin
            have_d = 1'b0;
            max_d  = '0;
            idx_d  = '0;
        end else if (vld_i && (!have_q || (val_i > max_q))) begin
            // Strict compare: on a tie the earlier (lower) index is kept.
            have_d = 1'b1;
            max_d  = val_i;
            idx_d  = idx_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            have_q <= 1'b0;
            max_q  <= '0;
            idx_q  <= '0;
        end else begin
            have_q <= have_d;
            max_q  <= max_d;
            idx_q  <= idx_d;
        end
    end

    assign max_o = max_d;
    assign idx_o = idx_d;

endmodule

// File: rtl/fc_scheduler.sv
// Sequences one FC inference: clear, align, stream features, wait for scores, capture.
// Define FC_ARGMAX_EN to pick the winning class; otherwise the last score is reported.
module fc_scheduler
    import fc_pkg::*;
#(
    parameter int unsigned NUM_IN    = NUM_IN_DEF,
    parameter int unsigned NUM_OUT   = NUM_OUT_DEF,
    parameter int unsigned CLR_CYC   = 6,
    parameter int unsigned ALIGN_DLY = 3,
    parameter int unsigned TIMEOUT   = 512
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             start,
    fc_scheduler_if.master   fc,
    output logic             busy,
    output logic             done,
    output logic             err_timeout,
    output logic [IDX_W-1:0] class_idx,
    output score_t           class_score
);

    localparam int unsigned CntMax = max_of(max_of(CLR_CYC, ALIGN_DLY),
                                            max_of(max_of(NUM_IN, NUM_OUT), TIMEOUT));
    localparam int unsigned CntW   = max_of($clog2(CntMax + 1), ADDR_W);

    typedef logic [CntW-1:0] cnt_t;

    fc_state_e        state_q, state_d;
    cnt_t             cnt_q, cnt_d;
    logic             err_q, err_d;
    logic [IDX_W-1:0] cls_idx_q, cls_idx_d;
    score_t           cls_score_q, cls_score_d;
    logic             rd_vld_q;
    feat_t            fan_in_q, fan_in_d;
    logic             feat_rd;
    logic [IDX_W-1:0] res_idx;
    score_t           res_score;

`ifdef FC_ARGMAX_EN
    logic am_clr;
    logic am_vld;

    assign am_clr = (state_q == StClear);
    assign am_vld = (state_q == StCapture);

    fc_argmax #(
        .IdxW (IDX_W)
    ) u_argmax (
        .clk_i  (clk_in),
        .rst_ni (rst_n),
        .clr_i  (am_clr),
        .vld_i  (am_vld),
        .idx_i  (IDX_W'(cnt_q)),
        .val_i  (fc.fc_fan_out),
        .max_o  (res_score),
        .idx_o  (res_idx)
    );
`else
    assign res_score = fc.fc_fan_out;
    assign res_idx   = '0;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        err_d       = err_q;
        cls_idx_d   = cls_idx_q;
        cls_score_d = cls_score_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StClear;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                end
            end
            StClear: begin
                if (cnt_q == cnt_t'(CLR_CYC - 1)) begin
                    state_d = StAlign;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StAlign: begin
                if (cnt_q == cnt_t'(ALIGN_DLY - 1)) begin
                    state_d = StStream;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StStream: begin
                if (cnt_q == cnt_t'(NUM_IN - 1)) begin
                    state_d = StWait;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StWait: begin
                if (!fc.fc_ready) begin
                    state_d = StCapture;
                    cnt_d   = '0;
                end else if (cnt_q == cnt_t'(TIMEOUT - 1)) begin
                    state_d     = StDone;
                    cnt_d       = '0;
                    err_d       = 1'b1;
                    cls_idx_d   = '0;
                    cls_score_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StCapture: begin
                // Result registers load on the same edge that enters DONE.
                if (cnt_q == cnt_t'(NUM_OUT - 1)) begin
                    state_d     = StDone;
                    cnt_d       = '0;
                    cls_idx_d   = res_idx;
                    cls_score_d = res_score;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    assign feat_rd  = (state_q == StStream);
    assign fan_in_d = rd_vld_q ? fc.feat_rdata : '0;

    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            err_q       <= 1'b0;
            cls_idx_q   <= '0;
            cls_score_q <= '0;
            rd_vld_q    <= 1'b0;
            fan_in_q    <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            cls_idx_q   <= cls_idx_d;
            cls_score_q <= cls_score_d;
            rd_vld_q    <= feat_rd;
            fan_in_q    <= fan_in_d;
        end
    end

    assign fc.feat_rd   = feat_rd;
    assign fc.feat_addr = feat_rd ? ADDR_W'(cnt_q) : '0;
    assign fc.fc_rst    = (state_q == StIdle) || (state_q == StClear) || (state_q == StDone);
    assign fc.fc_fan_in = fan_in_q;

    assign busy        = (state_q != StIdle);
    assign done        = (state_q == StDone);
    assign err_timeout = err_q;
    assign class_idx   = cls_idx_q;
    assign class_score = cls_score_q;

endmodule

// File: tb/tb_fc_scheduler.sv
// Directed bench for fc_scheduler with a feature RAM (feature[a]=a) and a behavioural
// FC datapath that drops ready 10 cycles after the stream and emits scores after that.
module tb_fc_scheduler;
    import fc_pkg::*;

`ifdef FC_ARGMAX_EN
    localparam int ExpIdxN = 6;
    localparam int ExpScN  = 2178;
    localparam int ExpIdxT = 3;
    localparam int ExpScT  = 400;
`else
    localparam int ExpIdxN = 0;
    localparam int ExpScN  = -2172;
    localparam int ExpIdxT = 0;
    localparam int ExpScT  = -7;
`endif

    logic       clk_in = 1'b0;
    logic       rst_n;
    logic       start;
    logic       busy;
    logic       done;
    logic       err_timeout;
    logic [3:0] class_idx;
    score_t     class_score;

    fc_scheduler_if fcif ();

    fc_scheduler #(
        .NUM_IN    (120),
        .NUM_OUT   (10),
        .CLR_CYC   (6),
        .ALIGN_DLY (3),
        .TIMEOUT   (512)
    ) dut (
        .clk_in      (clk_in),
        .rst_n       (rst_n),
        .start       (start),
        .fc          (fcif),
        .busy        (busy),
        .done        (done),
        .err_timeout (err_timeout),
        .class_idx   (class_idx),
        .class_score (class_score)
    );

    always #5 clk_in = ~clk_in;

    int scores [10];
    bit fc_en = 1'b1;
    int mcnt  = 0;
    int nc    = 0;
    int nm    = 0;

    always @(posedge clk_in) begin : ram_model
        fcif.feat_rdata <= feat_t'({9'd0, fcif.feat_addr});
    end

    // n=1 is the first cycle after the last stream read; ready low on n=10..20,
    // scores driven on n=11..20.
    always @(posedge clk_in) begin : fc_model
        int n;
        n = mcnt;
        if (!rst_n) n = 0;
        else if (fcif.feat_rd && fcif.feat_addr == 7'd119) n = 1;
        else if (n != 0) n = (n >= 30) ? 0 : n + 1;
        mcnt <= n;
        fcif.fc_ready   <= !(fc_en && n >= 10 && n <= 20);
        fcif.fc_fan_out <= (fc_en && n >= 11 && n <= 20) ? score_t'(scores[n - 11]) : '0;
    end

    int n_reads, rd_err, fanin_err, fcrst_err, busy_err;
    int done_cyc, done_cnt, err_cyc, idx_done, sc_done, idx_last, sc_last, err_at1, err_last;

    // Cycle 0 carries start; expected timing: CLEAR 1..6, ALIGN 7..9, reads 10..129.
    task automatic run_trace(input int xs0, input int xs1, input int ncyc, input int exp_done);
        logic exp_rd;
        int   exp_fi;
        n_reads = 0; rd_err = 0; fanin_err = 0; fcrst_err = 0; busy_err = 0;
        done_cyc = -1; done_cnt = 0; err_cyc = -1; err_at1 = -1;
        idx_done = -1; sc_done = -1;
        for (int c = 0; c < ncyc; c++) begin
            @(posedge clk_in); #1;
            start  = (c == 0 || c == xs0 || c == xs1);
            exp_rd = (c >= 10 && c < 130);
            if (fcif.feat_rd) n_reads++;
            if (fcif.feat_rd !== exp_rd || (exp_rd && int'(fcif.feat_addr) != c - 10)) rd_err++;
            exp_fi = (c >= 12 && c < 132) ? c - 12 : 0;
            if (int'(fcif.fc_fan_in) != exp_fi) fanin_err++;
            if (fcif.fc_rst !== (c < 7 || c >= exp_done)) fcrst_err++;
            if (busy !== (c >= 1 && c <= exp_done)) busy_err++;
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) begin
                    done_cyc = c;
                    idx_done = int'(class_idx);
                    sc_done  = int'(class_score);
                end
            end
            if (err_timeout && err_cyc < 0) err_cyc = c;
            if (c == 1) err_at1 = int'(err_timeout);
        end
        start    = 1'b0;
        idx_last = int'(class_idx);
        sc_last  = int'(class_score);
        err_last = int'(err_timeout);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        repeat (3) @(posedge clk_in);
        #1;
        nc++; if (busy !== 1'b0) begin nm++; $display("FAIL reset_busy: got %b want 0", busy); end
        nc++; if (done !== 1'b0) begin nm++; $display("FAIL reset_done: got %b want 0", done); end
        nc++; if (err_timeout !== 1'b0) begin nm++; $display("FAIL reset_err: got %b want 0", err_timeout); end
        nc++; if (fcif.fc_rst !== 1'b1) begin nm++; $display("FAIL reset_fc_rst: got %b want 1", fcif.fc_rst); end
        nc++; if (fcif.feat_rd !== 1'b0) begin nm++; $display("FAIL reset_feat_rd: got %b want 0", fcif.feat_rd); end
        nc++; if (fcif.feat_addr !== 7'd0) begin nm++; $display("FAIL reset_addr: got %0d want 0", fcif.feat_addr); end
        nc++; if (fcif.fc_fan_in !== 16'sd0) begin nm++; $display("FAIL reset_fan_in: got %0d want 0", fcif.fc_fan_in); end
        nc++; if (class_idx !== 4'd0) begin nm++; $display("FAIL reset_idx: got %0d want 0", class_idx); end
        nc++; if (class_score !== 20'sd0) begin nm++; $display("FAIL reset_score: got %0d want 0", class_score); end
        rst_n = 1'b1;
        repeat (2) @(posedge clk_in);
    endtask

    task automatic test_inference();
        scores = '{5, -3, 900, 12, -2305, 899, 2178, 0, 826, -2172};
        fc_en  = 1'b1;
        run_trace(-1, -1, 160, 150);
        nc++; if (n_reads != 120) begin nm++; $display("FAIL inf_reads: got %0d want 120", n_reads); end
        nc++; if (rd_err != 0) begin nm++; $display("FAIL inf_read_seq: got %0d bad cycles want 0", rd_err); end
        nc++; if (fanin_err != 0) begin nm++; $display("FAIL inf_fan_in: got %0d bad cycles want 0", fanin_err); end
        nc++; if (fcrst_err != 0) begin nm++; $display("FAIL inf_fc_rst: got %0d bad cycles want 0", fcrst_err); end
        nc++; if (busy_err != 0) begin nm++; $display("FAIL inf_busy: got %0d bad cycles want 0", busy_err); end
        nc++; if (done_cyc != 150) begin nm++; $display("FAIL inf_done_cyc: got %0d want 150", done_cyc); end
        nc++; if (done_cnt != 1) begin nm++; $display("FAIL inf_done_pulses: got %0d want 1", done_cnt); end
        nc++; if (idx_done != ExpIdxN) begin nm++; $display("FAIL inf_idx: got %0d want %0d", idx_done, ExpIdxN); end
        nc++; if (sc_done != ExpScN) begin nm++; $display("FAIL inf_score: got %0d want %0d", sc_done, ExpScN); end
        nc++; if (idx_last != ExpIdxN || sc_last != ExpScN) begin
            nm++; $display("FAIL inf_hold: got %0d/%0d want %0d/%0d", idx_last, sc_last, ExpIdxN, ExpScN);
        end
    endtask

    task automatic test_start_ignored();
        scores = '{5, -3, 900, 12, -2305, 899, 2178, 0, 826, -2172};
        run_trace(50, 150, 160, 150);
        nc++; if (n_reads != 120) begin nm++; $display("FAIL ign_reads: got %0d want 120", n_reads); end
        nc++; if (rd_err != 0) begin nm++; $display("FAIL ign_read_seq: got %0d bad cycles want 0", rd_err); end
        nc++; if (done_cyc != 150) begin nm++; $display("FAIL ign_done_cyc: got %0d want 150", done_cyc); end
        nc++; if (done_cnt != 1) begin nm++; $display("FAIL ign_done_pulses: got %0d want 1", done_cnt); end
        nc++; if (busy_err != 0) begin nm++; $display("FAIL ign_busy: got %0d bad cycles want 0", busy_err); end
        nc++; if (idx_done != ExpIdxN || sc_done != ExpScN) begin
            nm++; $display("FAIL ign_result: got %0d/%0d want %0d/%0d", idx_done, sc_done, ExpIdxN, ExpScN);
        end
    endtask

    task automatic test_tie();
        scores = '{-7, -7, -7, 400, -7, -7, -7, -7, 400, -7};
        run_trace(-1, -1, 160, 150);
        nc++; if (done_cyc != 150) begin nm++; $display("FAIL tie_done_cyc: got %0d want 150", done_cyc); end
        nc++; if (idx_done != ExpIdxT) begin nm++; $display("FAIL tie_idx: got %0d want %0d", idx_done, ExpIdxT); end
        nc++; if (sc_done != ExpScT) begin nm++; $display("FAIL tie_score: got %0d want %0d", sc_done, ExpScT); end
    endtask

    task automatic test_timeout();
        fc_en = 1'b0;
        // Reads end at cycle 129; 512 WAIT cycles 130..641; DONE with error at 642.
        run_trace(-1, -1, 660, 642);
        nc++; if (err_cyc != 642) begin nm++; $display("FAIL to_err_cyc: got %0d want 642", err_cyc); end
        nc++; if (done_cyc != 642) begin nm++; $display("FAIL to_done_cyc: got %0d want 642", done_cyc); end
        nc++; if (done_cnt != 1) begin nm++; $display("FAIL to_done_pulses: got %0d want 1", done_cnt); end
        nc++; if (idx_done != 0 || sc_done != 0) begin
            nm++; $display("FAIL to_result: got %0d/%0d want 0/0", idx_done, sc_done);
        end
        nc++; if (fcrst_err != 0 || busy_err != 0) begin
            nm++; $display("FAIL to_status: got %0d/%0d bad cycles want 0/0", fcrst_err, busy_err);
        end
        nc++; if (err_last != 1) begin nm++; $display("FAIL to_err_sticky: got %0d want 1", err_last); end
        fc_en  = 1'b1;
        scores = '{5, -3, 900, 12, -2305, 899, 2178, 0, 826, -2172};
        run_trace(-1, -1, 160, 150);
        nc++; if (err_at1 != 0) begin nm++; $display("FAIL to_err_clear: got %0d want 0", err_at1); end
        nc++; if (idx_done != ExpIdxN || sc_done != ExpScN) begin
            nm++; $display("FAIL to_rerun: got %0d/%0d want %0d/%0d", idx_done, sc_done, ExpIdxN, ExpScN);
        end
    endtask

    task automatic test_reset_mid_stream();
        bit found;
        found = 1'b0;
        scores = '{5, -3, 900, 12, -2305, 899, 2178, 0, 826, -2172};
        @(posedge clk_in); #1;
        start = 1'b1;
        @(posedge clk_in); #1;
        start = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (fcif.feat_rd === 1'b1 && fcif.feat_addr == 7'd60) begin
                found = 1'b1;
                break;
            end
            @(posedge clk_in); #1;
        end
        nc++; if (found !== 1'b1) begin nm++; $display("FAIL mid_reach_addr60: got %b want 1", found); end
        rst_n = 1'b0;
        @(posedge clk_in); #1;
        rst_n = 1'b1;
        nc++; if (busy !== 1'b0) begin nm++; $display("FAIL mid_busy: got %b want 0", busy); end
        nc++; if (fcif.fc_rst !== 1'b1) begin nm++; $display("FAIL mid_fc_rst: got %b want 1", fcif.fc_rst); end
        nc++; if (fcif.feat_rd !== 1'b0) begin nm++; $display("FAIL mid_feat_rd: got %b want 0", fcif.feat_rd); end
        nc++; if (fcif.fc_fan_in !== 16'sd0) begin nm++; $display("FAIL mid_fan_in: got %0d want 0", fcif.fc_fan_in); end
        nc++; if (class_idx !== 4'd0 || class_score !== 20'sd0) begin
            nm++; $display("FAIL mid_class: got %0d/%0d want 0/0", class_idx, class_score);
        end
        run_trace(-1, -1, 160, 150);
        nc++; if (n_reads != 120 || rd_err != 0) begin
            nm++; $display("FAIL mid_rerun_reads: got %0d reads %0d bad want 120/0", n_reads, rd_err);
        end
        nc++; if (fanin_err != 0) begin nm++; $display("FAIL mid_rerun_fan_in: got %0d bad cycles want 0", fanin_err); end
        nc++; if (done_cyc != 150 || done_cnt != 1) begin
            nm++; $display("FAIL mid_rerun_done: got cyc %0d pulses %0d want 150/1", done_cyc, done_cnt);
        end
        nc++; if (idx_done != ExpIdxN || sc_done != ExpScN) begin
            nm++; $display("FAIL mid_rerun_result: got %0d/%0d want %0d/%0d", idx_done, sc_done, ExpIdxN, ExpScN);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got simulation still running want finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        scores = '{5, -3, 900, 12, -2305, 899, 2178, 0, 826, -2172};
        test_reset();
        test_inference();
        test_start_ignored();
        test_tie();
        test_timeout();
        test_reset_mid_stream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nc, nm);
        $finish;
    end

endmodule
